// File: rtl/serial_flow_pkg.sv
// Shared types and helpers for the serial flow adder/comparator.
package serial_flow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_CMP = 1'b1
  } mode_t;

  // Elaboration-time ceiling log2, used to size the bit counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_bit_alu.sv
// One-bit serial step: full-adder slice in ADD mode, LSB-first magnitude compare in CMP mode.
module serial_bit_alu
  import serial_flow_pkg::*;
(
  input  logic  a,
  input  logic  b,
  input  logic  c,
  input  logic  gt,
  input  logic  neq,
  input  mode_t mode,
  output logic  out_bit,
  output logic  c_next,
  output logic  gt_next,
  output logic  neq_next
);

  always_comb begin
    out_bit  = a ^ b;
    c_next   = 1'b0;
    gt_next  = gt;
    neq_next = neq;
    if (mode == MODE_ADD) begin
      out_bit = a ^ b ^ c;
      c_next  = (a & b) | (c & (a ^ b));
    end else begin
      // Later (more significant) differing bits override earlier ones.
      if (a != b) gt_next = a;
      neq_next = neq | (a ^ b);
    end
  end

endmodule

// File: rtl/serial_flow_adder.sv
// Word-oriented serial adder/comparator over two LSB-first bit streams.
// Handshake: a bit pair is accepted on a rising edge when valid_i && ready_o; ready_o is low only in the single DONE cycle, clear_i overrides and discards any presented pair.
module serial_flow_adder
  import serial_flow_pkg::*;
#(
  parameter int WORD_W = 4,
  parameter bit SIGNED = 1'b0,
  localparam int CNT_W = clog2(WORD_W)
) (
  input  logic             clock,
  input  logic             nRESET_G,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             LINE1,
  input  logic             LINE2,
  input  logic             mode_i,
  input  logic             clear_i,
  output logic             OUTP_REG,
  output logic             OVERFLW_REG,
  output logic             GT_REG,
  output logic             EQ_REG,
  output logic             word_done_o,
  output logic [CNT_W-1:0] bit_idx_o,
  output logic [1:0]       state_o
);

  state_t           state_q;
  mode_t            mode_q;
  mode_t            cur_mode;
  logic [CNT_W-1:0] bit_idx_q;
  logic             carry_q, gt_q, neq_q;
  logic             outp_q, ovf_q, gtf_q, eqf_q;
  logic             out_bit, c_next, gt_next, neq_next;
  logic             accept, last_bit;

  assign ready_o     = (state_q != DONE);
  assign word_done_o = (state_q == DONE);
  assign accept      = valid_i & ready_o;
  assign last_bit    = (bit_idx_q == CNT_W'(WORD_W - 1));
  // mode_i only matters on the first bit of a word; afterwards the latched mode rules.
  assign cur_mode    = (state_q == IDLE) ? mode_t'(mode_i) : mode_q;

  assign OUTP_REG    = outp_q;
  assign OVERFLW_REG = ovf_q;
  assign GT_REG      = gtf_q;
  assign EQ_REG      = eqf_q;
  assign bit_idx_o   = bit_idx_q;
  assign state_o     = state_q;

  serial_bit_alu u_alu (
    .a        (LINE1),
    .b        (LINE2),
    .c        (carry_q),
    .gt       (gt_q),
    .neq      (neq_q),
    .mode     (cur_mode),
    .out_bit  (out_bit),
    .c_next   (c_next),
    .gt_next  (gt_next),
    .neq_next (neq_next)
  );

  always_ff @(posedge clock or negedge nRESET_G) begin
    if (!nRESET_G) begin
      state_q   <= IDLE;
      mode_q    <= MODE_ADD;
      bit_idx_q <= '0;
      carry_q   <= 1'b0;
      gt_q      <= 1'b0;
      neq_q     <= 1'b0;
      outp_q    <= 1'b0;
      ovf_q     <= 1'b0;
      gtf_q     <= 1'b0;
      eqf_q     <= 1'b0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      carry_q   <= 1'b0;
      gt_q      <= 1'b0;
      neq_q     <= 1'b0;
      outp_q    <= 1'b0;
      ovf_q     <= 1'b0;
      gtf_q     <= 1'b0;
      eqf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            outp_q <= out_bit;
            if (state_q == IDLE) mode_q <= cur_mode;
            if (last_bit) begin
              // Flags are loaded here so they are visible during the DONE cycle.
              state_q   <= DONE;
              bit_idx_q <= '0;
              carry_q   <= 1'b0;
              gt_q      <= 1'b0;
              neq_q     <= 1'b0;
              if (cur_mode == MODE_ADD) begin
                ovf_q <= SIGNED ? (carry_q ^ c_next) : c_next;
                gtf_q <= 1'b0;
                eqf_q <= 1'b0;
              end else begin
                ovf_q <= 1'b0;
                gtf_q <= gt_next;
                eqf_q <= ~neq_next;
              end
            end else begin
              state_q   <= ACC;
              bit_idx_q <= bit_idx_q + CNT_W'(1);
              carry_q   <= c_next;
              gt_q      <= gt_next;
              neq_q     <= neq_next;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_flow_adder.sv
// Bench for serial_flow_adder: unsigned and signed instances share one stimulus stream, checked by a scoreboard.
module tb_serial_flow_adder;

  logic       clock = 1'b0;
  logic       nRESET_G = 1'b0;
  logic       valid_i = 1'b0;
  logic       LINE1 = 1'b0;
  logic       LINE2 = 1'b0;
  logic       mode_i = 1'b0;
  logic       clear_i = 1'b0;

  logic       ready_u, outp_u, ovf_u, gt_u, eq_u, done_u;
  logic       ready_s, outp_s, ovf_s, gt_s, eq_s, done_s;
  logic [1:0] bit_idx_u, bit_idx_s, state_u, state_s;

  int checks = 0;
  int errors = 0;

  logic [0:0] exp_bit_q[$];
  logic [3:0] exp_flag_q[$];   // {ovf_unsigned, ovf_signed, gt, eq}
  logic       acc_d = 1'b0;

  always #5 clock = ~clock;

  serial_flow_adder #(.WORD_W(4), .SIGNED(1'b0)) u_dut_u (
    .clock(clock), .nRESET_G(nRESET_G), .valid_i(valid_i), .ready_o(ready_u),
    .LINE1(LINE1), .LINE2(LINE2), .mode_i(mode_i), .clear_i(clear_i),
    .OUTP_REG(outp_u), .OVERFLW_REG(ovf_u), .GT_REG(gt_u), .EQ_REG(eq_u),
    .word_done_o(done_u), .bit_idx_o(bit_idx_u), .state_o(state_u)
  );

  serial_flow_adder #(.WORD_W(4), .SIGNED(1'b1)) u_dut_s (
    .clock(clock), .nRESET_G(nRESET_G), .valid_i(valid_i), .ready_o(ready_s),
    .LINE1(LINE1), .LINE2(LINE2), .mode_i(mode_i), .clear_i(clear_i),
    .OUTP_REG(outp_s), .OVERFLW_REG(ovf_s), .GT_REG(gt_s), .EQ_REG(eq_s),
    .word_done_o(done_s), .bit_idx_o(bit_idx_s), .state_o(state_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on whole words.
  function automatic logic exp_bit(input logic [3:0] a, input logic [3:0] b, input logic md, input int i);
    int s;
    if (md) s = int'(a ^ b);
    else    s = int'(a) + int'(b);
    return logic'((s >> i) & 1);
  endfunction

  function automatic logic [3:0] exp_flags(input logic [3:0] a, input logic [3:0] b, input logic md);
    int ua, ub, sa, sb, us, ss;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    us = ua + ub;
    ss = sa + sb;
    if (md) return {2'b00, ua > ub, ua == ub};
    return {us > 15, (ss > 7) || (ss < -8), 2'b00};
  endfunction

  // Monitor: one registered output bit per accept, one flag set per word_done pulse.
  always @(posedge clock) acc_d <= valid_i && ready_u && !clear_i && nRESET_G;

  always @(negedge clock) begin
    logic [0:0] e;
    logic [3:0] f;
    if (acc_d) begin
      if (exp_bit_q.size() == 0) check("bit_queue_empty", 32'd1, 32'd0);
      else begin
        e = exp_bit_q.pop_front();
        check("outp_u", 32'(outp_u), 32'(e));
        check("outp_s", 32'(outp_s), 32'(e));
      end
    end
    if (done_u || done_s) begin
      if (exp_flag_q.size() == 0) check("unexpected_word_done", 32'd1, 32'd0);
      else begin
        f = exp_flag_q.pop_front();
        check("done_s", 32'(done_s), 32'(done_u));
        check("ovf_u", 32'(ovf_u), 32'(f[3]));
        check("ovf_s", 32'(ovf_s), 32'(f[2]));
        check("gt_u",  32'(gt_u),  32'(f[1]));
        check("gt_s",  32'(gt_s),  32'(f[1]));
        check("eq_u",  32'(eq_u),  32'(f[0]));
        check("eq_s",  32'(eq_s),  32'(f[0]));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!(ready_u && ready_s)) begin
      @(posedge clock); #1;
      n++;
      if (n > 20) begin
        check("ready_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_outp_u"}, 32'(outp_u), 32'd0);
    check({tag, "_ovf_u"}, 32'(ovf_u), 32'd0);
    check({tag, "_ovf_s"}, 32'(ovf_s), 32'd0);
    check({tag, "_gt"}, 32'(gt_u | gt_s), 32'd0);
    check({tag, "_eq"}, 32'(eq_u | eq_s), 32'd0);
    check({tag, "_bit_idx"}, 32'(bit_idx_u), 32'd0);
    check({tag, "_done"}, 32'(done_u | done_s), 32'd0);
    check({tag, "_ready"}, 32'(ready_u & ready_s), 32'd1);
  endtask

  // abort_kind: 0 none, 1 clear_i after bit 2, 2 reset pulse after bit 2.
  task automatic send_word(input logic [3:0] a, input logic [3:0] b, input logic md,
                           input bit toggle, input int stall_after, input int abort_kind, input bit gaps);
    int n_bits;
    n_bits = (abort_kind != 0) ? 3 : 4;
    for (int i = 0; i < n_bits; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        mode_i  = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 2)) begin @(posedge clock); #1; end
      end
      valid_i = 1'b1;
      LINE1   = a[i];
      LINE2   = b[i];
      mode_i  = (i == 0) ? md : (toggle ? ~md : md);
      exp_bit_q.push_back(exp_bit(a, b, md, i));
      wait_ready();
      @(posedge clock); #1;
      if (i == stall_after) begin
        valid_i = 1'b0;
        LINE1   = 1'($urandom_range(0, 1));
        LINE2   = 1'($urandom_range(0, 1));
        repeat (3) begin
          @(posedge clock); #1;
          check("stall_bit_idx", 32'(bit_idx_u), 32'(i + 1));
          check("stall_outp", 32'(outp_u), 32'(exp_bit(a, b, md, i)));
        end
      end
    end
    valid_i = 1'b0;
    if (abort_kind == 0) begin
      exp_flag_q.push_back(exp_flags(a, b, md));
      check("done_pulse", 32'(done_u), 32'd1);
      check("done_ready_low", 32'(ready_u | ready_s), 32'd0);
      check("done_bit_idx", 32'(bit_idx_u), 32'd0);
      @(posedge clock); #1;
      check("after_done_ready", 32'(ready_u & ready_s), 32'd1);
      check("after_done_pulse", 32'(done_u | done_s), 32'd0);
    end else if (abort_kind == 1) begin
      clear_i = 1'b1;
      valid_i = 1'b1;
      LINE1   = 1'b1;
      LINE2   = 1'b1;
      @(posedge clock); #1;
      clear_i = 1'b0;
      valid_i = 1'b0;
      check_cleared("clear");
    end else begin
      @(negedge clock); #1;
      nRESET_G = 1'b0;
      #1;
      check_cleared("reset");
      #1;
      nRESET_G = 1'b1;
      @(posedge clock); #1;
      check_cleared("post_reset");
    end
  endtask

  initial begin
    #2;
    check_cleared("por");
    #10;
    nRESET_G = 1'b1;
    @(posedge clock); #1;

    send_word(4'd5,  4'd3,  1'b0, 1'b0, -1, 0, 1'b0);
    send_word(4'd9,  4'd8,  1'b0, 1'b0, -1, 0, 1'b0);
    send_word(4'd1,  4'd1,  1'b0, 1'b0, -1, 0, 1'b0);
    send_word(4'd7,  4'd1,  1'b0, 1'b0, -1, 0, 1'b0);
    send_word(4'd15, 4'd1,  1'b0, 1'b0, -1, 0, 1'b0);
    send_word(4'd6,  4'd5,  1'b1, 1'b0, -1, 0, 1'b0);
    send_word(4'd10, 4'd10, 1'b1, 1'b0, -1, 0, 1'b0);
    send_word(4'd2,  4'd12, 1'b1, 1'b0, -1, 0, 1'b0);
    send_word(4'd6,  4'd5,  1'b1, 1'b1, -1, 0, 1'b0);
    send_word(4'd9,  4'd8,  1'b0, 1'b1, -1, 0, 1'b0);
    send_word(4'd9,  4'd8,  1'b0, 1'b0,  1, 0, 1'b0);
    send_word(4'd9,  4'd8,  1'b0, 1'b0, -1, 1, 1'b0);
    send_word(4'd5,  4'd3,  1'b0, 1'b0, -1, 0, 1'b0);
    send_word(4'd9,  4'd8,  1'b0, 1'b0, -1, 0, 1'b0);
    send_word(4'd9,  4'd8,  1'b0, 1'b0, -1, 2, 1'b0);
    send_word(4'd5,  4'd3,  1'b0, 1'b0, -1, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      send_word(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, 1'b1);
    end

    repeat (3) begin @(posedge clock); #1; end
    check("bit_queue_drained", 32'(exp_bit_q.size()), 32'd0);
    check("flag_queue_drained", 32'(exp_flag_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
